// File: rtl/aes_gcm_ghash_stage.sv
// aes_gcm_ghash_stage: final GCM stage. It produces ciphertext from the AES
// keystream, folds AAD, ciphertext and length blocks into the GHASH
// accumulator with a byte-serial GF(2^128) multiplier (16 cycles per block),
// and emits the authentication tag after the length block.
// Optional build macro AES_GCM_DECRYPT_EN adds i_decrypt. When i_decrypt is
// set, the input block is hashed as ciphertext.
module aes_gcm_ghash_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  input  logic [0:2]   i_phase,
  input  logic [0:127] i_plain_text,
  input  logic [0:127] i_aad,
  input  logic [0:127] i_h,
  input  logic [0:127] i_encrypted_j0,
  input  logic [0:127] i_encrypted_cb,
  input  logic [0:127] i_instance_size,
  input  logic         i_new_instance,
`ifdef AES_GCM_DECRYPT_EN
  input  logic         i_decrypt,
`endif
  output logic         o_ready,
  output logic [0:127] o_cipher_text,
  output logic         o_cipher_valid,
  output logic [0:127] o_tag,
  output logic         o_tag_valid
);

  localparam int DATA_W = 128;
  typedef logic [0:DATA_W-1] blk_t;
  // Reduction constant: 11100001 followed by 120 zero bits.
  localparam blk_t GF_R = {8'he1, 120'd0};

  typedef enum logic [1:0] {IDLE, MUL, TAG} state_t;

  state_t     state, state_next;
  logic       start, last;
  blk_t       cipher, absorb;
  blk_t       y_q, v_q, x_q, h_q, ej0_q;
  blk_t       y_step, v_step;
  logic [3:0] cnt;
  logic       len_q;

  // Eight iterations of the bit-serial GHASH multiply. The first digit bit is
  // the most significant bit of the block. z accumulates the product. v is H
  // times x^i.
  function automatic logic [0:2*DATA_W-1] gf_digit(input blk_t z_in,
                                                   input blk_t v_in,
                                                   input logic [0:7] d);
    blk_t z, v;
    z = z_in;
    v = v_in;
    for (int j = 0; j < 8; j++) begin
      if (d[j]) z = z ^ v;
      if (v[DATA_W-1]) v = (v >> 1) ^ GF_R;
      else             v = v >> 1;
    end
    return {z, v};
  endfunction

  // Select the block that is hashed for the current phase.
  always_comb begin
    cipher = i_plain_text ^ i_encrypted_cb;
    absorb = '0;
    case (i_phase)
      3'd1: absorb = i_aad;
`ifdef AES_GCM_DECRYPT_EN
      3'd2: absorb = i_decrypt ? i_plain_text : cipher;
`else
      3'd2: absorb = cipher;
`endif
      3'd3: absorb = i_instance_size;
      default: absorb = '0;
    endcase
  end

  // Compute one byte step of the multiply from the current working registers.
  always_comb begin
    {y_step, v_step} = gf_digit(y_q, v_q, x_q[0:7]);
  end

  // Compute next state, handshake and stage strobes.
  always_comb begin
    state_next = state;
    o_ready    = 1'b0;
    start      = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid && (i_phase == 3'd1 || i_phase == 3'd2 || i_phase == 3'd3)) begin
          start      = 1'b1;
          state_next = MUL;
        end
      end
      MUL: begin
        last = (cnt == 4'd15);
        if (last) state_next = len_q ? TAG : IDLE;
      end
      TAG:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Update the GHASH working registers. On accept, load X = Y ^ block and
  // clear the accumulator. Y is rebuilt digit by digit during MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      v_q   <= '0;
      x_q   <= '0;
      h_q   <= '0;
      ej0_q <= '0;
      cnt   <= '0;
      len_q <= 1'b0;
    end else if (start) begin
      x_q   <= (i_new_instance ? {DATA_W{1'b0}} : y_q) ^ absorb;
      y_q   <= '0;
      v_q   <= i_new_instance ? i_h : h_q;
      if (i_new_instance) begin
        h_q   <= i_h;
        ej0_q <= i_encrypted_j0;
      end
      len_q <= (i_phase == 3'd3);
      cnt   <= '0;
    end else if (state == MUL) begin
      y_q <= y_step;
      v_q <= v_step;
      x_q <= x_q << 8;
      cnt <= cnt + 4'd1;
    end
  end

  // Update the registered outputs. The strobes last one cycle and the data
  // holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cipher_text  <= '0;
      o_cipher_valid <= 1'b0;
      o_tag          <= '0;
      o_tag_valid    <= 1'b0;
    end else begin
      o_cipher_valid <= 1'b0;
      o_tag_valid    <= 1'b0;
      if (start && i_phase == 3'd2) begin
        o_cipher_text  <= cipher;
        o_cipher_valid <= 1'b1;
      end
      if (last && len_q) begin
        o_tag       <= y_step ^ ej0_q;
        o_tag_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_gcm_ghash_stage.sv
// tb_aes_gcm_ghash_stage: tests the GHASH/tag stage.
// The NIST vectors are checked against fixed expected values. The randomized
// messages are checked against a behavioural model that uses polynomial
// multiplication with modular reduction. Handshake timing is checked every cycle.
// Define AES_GCM_DECRYPT_EN to build and test the decrypt variant.
module tb_aes_gcm_ghash_stage;

  localparam logic [127:0] H1   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] EJ1  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] ECB2 = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] T2   = 128'hab6e47d42cec13bdf53a67b21257bddf;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic [2:0]   i_phase;
  logic [127:0] i_plain_text, i_aad, i_h, i_encrypted_j0, i_encrypted_cb, i_instance_size;
  logic         i_new_instance;
  logic         i_decrypt;
  logic         o_ready, o_cipher_valid, o_tag_valid;
  logic [127:0] o_cipher_text, o_tag;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [127:0] m_y, m_h, m_ej0, exp_ct, exp_tag, shown_tag;

  aes_gcm_ghash_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_valid(i_valid),
    .i_phase(i_phase),
    .i_plain_text(i_plain_text),
    .i_aad(i_aad),
    .i_h(i_h),
    .i_encrypted_j0(i_encrypted_j0),
    .i_encrypted_cb(i_encrypted_cb),
    .i_instance_size(i_instance_size),
    .i_new_instance(i_new_instance),
`ifdef AES_GCM_DECRYPT_EN
    .i_decrypt(i_decrypt),
`endif
    .o_ready(o_ready),
    .o_cipher_text(o_cipher_text),
    .o_cipher_valid(o_cipher_valid),
    .o_tag(o_tag),
    .o_tag_valid(o_tag_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // GF(2^128) product. The bit string is treated as a polynomial whose first
  // bit is the x^0 coefficient. The factors are multiplied carry-less and the
  // result is reduced by x^128 = x^7 + x^2 + x + 1.
  function automatic logic [127:0] gf_mul(input logic [127:0] a, input logic [127:0] b);
    logic [127:0] ar, br, r;
    logic [254:0] p;
    for (int i = 0; i < 128; i++) begin
      ar[i] = a[127-i];
      br[i] = b[127-i];
    end
    p = '0;
    for (int i = 0; i < 128; i++)
      if (ar[i]) p = p ^ ({127'd0, br} << i);
    for (int k = 254; k >= 128; k--) begin
      if (p[k]) begin
        p[k]     = 1'b0;
        p[k-128] = ~p[k-128];
        p[k-127] = ~p[k-127];
        p[k-126] = ~p[k-126];
        p[k-121] = ~p[k-121];
      end
    end
    for (int i = 0; i < 128; i++) r[i] = p[127-i];
    return r;
  endfunction

  task automatic model_absorb(input logic [2:0] ph, input logic nw, input logic [127:0] aad,
                              input logic [127:0] pt, input logic [127:0] cb, input logic [127:0] h,
                              input logic [127:0] ej0, input logic [127:0] sz, input logic dec);
    logic [127:0] blk;
    if (ph >= 3'd1 && ph <= 3'd3) begin
      if (nw) begin
        m_y   = '0;
        m_h   = h;
        m_ej0 = ej0;
      end
      blk = (ph == 3'd1) ? aad : (ph == 3'd2) ? (dec ? pt : (pt ^ cb)) : sz;
      m_y = gf_mul(m_y ^ blk, m_h);
      if (ph == 3'd2) exp_ct = pt ^ cb;
      if (ph == 3'd3) exp_tag = m_y ^ m_ej0;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_junk();
    i_valid         = 1'($urandom);
    i_phase         = 3'($urandom);
    i_plain_text    = rnd128();
    i_aad           = rnd128();
    i_h             = rnd128();
    i_encrypted_j0  = rnd128();
    i_encrypted_cb  = rnd128();
    i_instance_size = rnd128();
    i_new_instance  = 1'($urandom);
    i_decrypt       = 1'($urandom);
  endtask

  // Wait for o_ready (bounded), present one block and pass the accept edge.
  task automatic accept_block(input logic [2:0] ph, input logic nw, input logic [127:0] aad,
                              input logic [127:0] pt, input logic [127:0] cb, input logic [127:0] h,
                              input logic [127:0] ej0, input logic [127:0] sz, input logic dec);
    int n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("ready_timeout", 128'(0), 128'(1));
    i_phase = ph; i_new_instance = nw; i_aad = aad; i_plain_text = pt;
    i_encrypted_cb = cb; i_h = h; i_encrypted_j0 = ej0; i_instance_size = sz;
    i_decrypt = dec; i_valid = 1'b1;
    @(posedge clk); #1;
    model_absorb(ph, nw, aad, pt, cb, h, ej0, sz, dec);
  endtask

  // Called in the first cycle after an accept. Checks the 16 busy cycles
  // while driving junk inputs, then checks the TAG cycle if one is expected.
  task automatic finish_block(input logic is_ct, input logic is_tag);
    for (int k = 1; k <= 16; k++) begin
      check("busy_ready", 128'(o_ready), 128'(0));
      if (is_ct && k == 1) check("ct_valid", 128'(o_cipher_valid), 128'(1));
      else                 check("ct_valid_quiet", 128'(o_cipher_valid), 128'(0));
      check("ct_data", o_cipher_text, exp_ct);
      check("tag_valid_quiet", 128'(o_tag_valid), 128'(0));
      check("tag_hold", o_tag, shown_tag);
      drive_junk();
      if (k == 16) i_valid = 1'b0;
      @(posedge clk); #1;
    end
    if (is_tag) begin
      check("tag_valid", 128'(o_tag_valid), 128'(1));
      check("tag_data", o_tag, exp_tag);
      check("tag_cycle_ready", 128'(o_ready), 128'(0));
      shown_tag = exp_tag;
      @(posedge clk); #1;
      check("tag_valid_drop", 128'(o_tag_valid), 128'(0));
      check("tag_hold_after", o_tag, shown_tag);
    end
    check("ready_back", 128'(o_ready), 128'(1));
  endtask

  task automatic ignored_block();
    logic [2:0] ph;
    ph = 3'($urandom_range(4, 8));
    accept_block(ph, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 1'b0);
    check("ignored_ready", 128'(o_ready), 128'(1));
    check("ignored_ct_valid", 128'(o_cipher_valid), 128'(0));
    i_valid = 1'b0;
  endtask

  task automatic nist_case2();
    accept_block(3'd2, 1'b1, rnd128(), 128'd0, ECB2, H1, EJ1, rnd128(), 1'b0);
    check("nist2_ct_first", o_cipher_text, ECB2);
    finish_block(1'b1, 1'b0);
    accept_block(3'd3, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 128'h80, 1'b0);
    finish_block(1'b0, 1'b1);
    check("nist2_tag", o_tag, T2);
  endtask

  initial begin
    logic [2:0]   ph;
    logic [127:0] aad_c;
    int           nb, accepts, last_c, c, tv_seen;
    logic         dec;

    m_y = '0; m_h = '0; m_ej0 = '0; exp_ct = '0; exp_tag = '0; shown_tag = '0;
    rst_n = 1'b0; i_valid = 1'b0; i_phase = '0; i_plain_text = '0; i_aad = '0; i_h = '0;
    i_encrypted_j0 = '0; i_encrypted_cb = '0; i_instance_size = '0; i_new_instance = 1'b0;
    i_decrypt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 128'(o_ready), 128'(1));
    check("rst_ct", o_cipher_text, 128'd0);
    check("rst_tag", o_tag, 128'd0);
    check("rst_ct_valid", 128'(o_cipher_valid), 128'(0));
    check("rst_tag_valid", 128'(o_tag_valid), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // NIST case 1: empty message
    accept_block(3'd3, 1'b1, rnd128(), rnd128(), rnd128(), H1, EJ1, 128'd0, 1'b0);
    finish_block(1'b0, 1'b1);
    check("nist1_tag", o_tag, EJ1);

    // NIST case 2
    nist_case2();

    // randomized messages with ignored phases interleaved
    for (int m = 0; m < 6; m++) begin
      ph  = 3'($urandom_range(1, 3));
      dec = 1'b0;
`ifdef AES_GCM_DECRYPT_EN
      dec = 1'($urandom);
`endif
      accept_block(ph, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), dec);
      finish_block(ph == 3'd2, ph == 3'd3);
      if (ph != 3'd3) begin
        nb = $urandom_range(0, 4);
        for (int b = 0; b < nb; b++) begin
          if ($urandom_range(0, 2) == 0) ignored_block();
          ph = 3'($urandom_range(1, 2));
`ifdef AES_GCM_DECRYPT_EN
          dec = 1'($urandom);
`endif
          accept_block(ph, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), dec);
          finish_block(ph == 3'd2, 1'b0);
        end
        ignored_block();
        accept_block(3'd3, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 1'b0);
        finish_block(1'b0, 1'b1);
      end
    end

    // second message with new_instance is independent of the first
    nist_case2();

    // i_valid held high: one accept every 17 cycles
    accept_block(3'd1, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 1'b0);
    finish_block(1'b0, 1'b0);
    aad_c = rnd128();
    i_phase = 3'd1; i_new_instance = 1'b0; i_aad = aad_c; i_decrypt = 1'b0; i_valid = 1'b1;
    accepts = 0; last_c = 0; c = 0;
    while (accepts < 3 && c < 200) begin
      if (o_ready) begin
        if (accepts > 0) check("thru_gap", 128'(c - last_c), 128'(17));
        last_c = c;
        accepts++;
        model_absorb(3'd1, 1'b0, aad_c, i_plain_text, i_encrypted_cb, i_h, i_encrypted_j0,
                     i_instance_size, 1'b0);
      end
      @(posedge clk); #1;
      c++;
    end
    i_valid = 1'b0;
    check("thru_count", 128'(accepts), 128'(3));
    accept_block(3'd3, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 1'b0);
    finish_block(1'b0, 1'b1);

    // reset during MUL cycle 8 of the case-2 length block
    accept_block(3'd2, 1'b1, rnd128(), 128'd0, ECB2, H1, EJ1, rnd128(), 1'b0);
    finish_block(1'b1, 1'b0);
    accept_block(3'd3, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 128'h80, 1'b0);
    i_valid = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 128'(o_ready), 128'(1));
    check("arst_ct", o_cipher_text, 128'd0);
    check("arst_tag", o_tag, 128'd0);
    check("arst_ct_valid", 128'(o_cipher_valid), 128'(0));
    check("arst_tag_valid", 128'(o_tag_valid), 128'(0));
    m_y = '0; m_h = '0; m_ej0 = '0; exp_ct = '0; exp_tag = '0; shown_tag = '0;
    #3;
    rst_n = 1'b1;
    tv_seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (o_tag_valid) tv_seen++;
    end
    check("no_tag_after_rst", 128'(tv_seen), 128'(0));
    accept_block(3'd3, 1'b1, rnd128(), rnd128(), rnd128(), H1, EJ1, 128'd0, 1'b0);
    finish_block(1'b0, 1'b1);
    check("nist1_after_rst", o_tag, EJ1);

`ifdef AES_GCM_DECRYPT_EN
    // case 2 in decrypt direction
    accept_block(3'd2, 1'b1, rnd128(), ECB2, ECB2, H1, EJ1, rnd128(), 1'b1);
    check("dec_pt", o_cipher_text, 128'd0);
    finish_block(1'b1, 1'b0);
    accept_block(3'd3, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 128'h80, 1'b0);
    finish_block(1'b0, 1'b1);
    check("dec_tag", o_tag, T2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
